// File: rtl/lane_accumulator.sv
// Reduces acc_len consecutive adder sums into one saturated result, full-width or two packed lanes.
// Result registered on the final accepted beat; in_ready is low while a result waits for out_ready.
module lane_accumulator #(
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        choose_8bit,
  input  logic        [CNT_WIDTH-1:0] acc_len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sat,
  output logic                        busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] OUTPUT = 2'd2;

  localparam int HI = IN_WIDTH / 2;
  localparam int HA = ACC_WIDTH / 2;
  localparam int HO = OUT_WIDTH / 2;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  localparam logic signed [ACC_WIDTH-1:0] FULL_MAX = {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] FULL_MIN = {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [HA-1:0]        LANE_MAX = {{(HA-HO+1){1'b0}}, {(HO-1){1'b1}}};
  localparam logic signed [HA-1:0]        LANE_MIN = {{(HA-HO+1){1'b1}}, {(HO-1){1'b0}}};

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 mode_q;
  logic [ACC_WIDTH-1:0] acc;

  logic                 accept;
  logic                 first;
  logic                 mode_eff;
  logic                 last;
  logic [CNT_WIDTH-1:0] len_eff;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH-1:0] acc_full;
  logic [HA-1:0]        acc_lo;
  logic [HA-1:0]        acc_hi;
  logic [ACC_WIDTH-1:0] acc_nxt;
  logic [OUT_WIDTH-1:0] sat_data;
  logic                 sat_flag;
  logic [HO:0]          lane_lo;
  logic [HO:0]          lane_hi;

  // Returns {clamped, value} for one packed lane.
  function automatic logic [HO:0] sat_lane(input logic [HA-1:0] v);
    if ($signed(v) > LANE_MAX)      sat_lane = {1'b1, 1'b0, {(HO-1){1'b1}}};
    else if ($signed(v) < LANE_MIN) sat_lane = {1'b1, 1'b1, {(HO-1){1'b0}}};
    else                            sat_lane = {1'b0, v[HO-1:0]};
  endfunction

  assign in_ready  = (state == IDLE) || (state == ACCUM);
  assign out_valid = (state == OUTPUT);
  assign busy      = (state != IDLE);

  always_comb begin
    accept   = in_valid & in_ready;
    first    = (state == IDLE);
    mode_eff = first ? choose_8bit : mode_q;
    len_eff  = (acc_len == '0) ? ONE : acc_len;
    cnt_nxt  = first ? ONE : cnt + ONE;
    last     = first ? (len_eff == ONE) : (cnt_nxt == len_q);
    // The first beat loads rather than adds, so stale accumulator contents never leak.
    base     = first ? '0 : acc;
    acc_full = base + {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    acc_lo   = base[HA-1:0] + {{(HA-HI){in_data[HI-1]}}, in_data[HI-1:0]};
    acc_hi   = base[ACC_WIDTH-1:HA] + {{(HA-HI){in_data[IN_WIDTH-1]}}, in_data[IN_WIDTH-1:HI]};
    acc_nxt  = mode_eff ? {acc_hi, acc_lo} : acc_full;

    lane_lo  = sat_lane(acc_nxt[HA-1:0]);
    lane_hi  = sat_lane(acc_nxt[ACC_WIDTH-1:HA]);
    sat_data = acc_nxt[OUT_WIDTH-1:0];
    sat_flag = 1'b0;
    if (mode_eff) begin
      sat_data = {lane_hi[HO-1:0], lane_lo[HO-1:0]};
      sat_flag = lane_hi[HO] | lane_lo[HO];
    end else if ($signed(acc_nxt) > FULL_MAX) begin
      sat_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      sat_flag = 1'b1;
    end else if ($signed(acc_nxt) < FULL_MIN) begin
      sat_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      len_q    <= '0;
      cnt      <= '0;
      mode_q   <= 1'b0;
      acc      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            if (first) begin
              len_q  <= len_eff;
              mode_q <= choose_8bit;
            end
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            if (last) begin
              state    <= OUTPUT;
              out_data <= sat_data;
              out_sat  <= sat_flag;
            end else begin
              state <= ACCUM;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_accumulator.sv
// Directed bench for lane_accumulator: full/packed sums, saturation, backpressure, mode latching, reset.
module tb_lane_accumulator;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        choose_8bit = 1'b0;
  logic [15:0] acc_len = 16'd1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_sat;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  lane_accumulator dut (
    .clk(clk), .reset(reset), .choose_8bit(choose_8bit), .acc_len(acc_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and returns just after the edge that accepted it.
  task automatic send(input logic [31:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    int n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (out_data !== 32'h0) begin fails++; $display("FAIL rst_data: got %h want 0", out_data); end
    checks++; if (out_sat !== 1'b0) begin fails++; $display("FAIL rst_sat: got %b want 0", out_sat); end
    step();
    reset = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_full_sum();
    choose_8bit = 1'b0; acc_len = 16'd3;
    send(32'd10);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL full_busy: got %b want 1", busy); end
    send(32'hFFFFFFFC);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_early: got %b want 0", out_valid); end
    send(32'd100);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL full_latency: got %b want 1", out_valid); end
    checks++; if (out_data !== 32'd106) begin fails++; $display("FAIL full_data: got %h want %h", out_data, 32'd106); end
    checks++; if (out_sat !== 1'b0) begin fails++; $display("FAIL full_sat: got %b want 0", out_sat); end
    handshake();
  endtask

  task automatic test_packed_sum();
    choose_8bit = 1'b1; acc_len = 16'd4;
    for (int i = 0; i < 4; i++) send(32'hFFFD0005);
    checks++; if (out_data !== 32'hFFF40014) begin fails++; $display("FAIL packed_data: got %h want fff40014", out_data); end
    checks++; if (out_sat !== 1'b0) begin fails++; $display("FAIL packed_sat: got %b want 0", out_sat); end
    handshake();
  endtask

  task automatic test_saturation();
    choose_8bit = 1'b0; acc_len = 16'd2;
    send(32'h7FFFFFFF); send(32'h7FFFFFFF);
    checks++; if (out_data !== 32'h7FFFFFFF) begin fails++; $display("FAIL sat_full_data: got %h want 7fffffff", out_data); end
    checks++; if (out_sat !== 1'b1) begin fails++; $display("FAIL sat_full_flag: got %b want 1", out_sat); end
    handshake();
    choose_8bit = 1'b1;
    send(32'h90007000); send(32'h90007000);
    checks++; if (out_data !== 32'h80007FFF) begin fails++; $display("FAIL sat_packed_data: got %h want 80007fff", out_data); end
    checks++; if (out_sat !== 1'b1) begin fails++; $display("FAIL sat_packed_flag: got %b want 1", out_sat); end
    handshake();
    choose_8bit = 1'b0;
  endtask

  task automatic test_backpressure();
    acc_len = 16'd1;
    send(32'd5);
    in_valid = 1'b1; in_data = 32'd99; acc_len = 16'd2;
    for (int i = 0; i < 5; i++) begin
      checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== 32'd5) begin fails++; $display("FAIL bp_hold[%0d]: got v=%b d=%h want v=1 d=5", i, out_valid, out_data); end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
    step();
    in_data = 32'd1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd100) begin fails++; $display("FAIL bp_fresh: got v=%b d=%h want v=1 d=64", out_valid, out_data); end
    handshake();
  endtask

  task automatic test_len_zero_and_mode_latch();
    choose_8bit = 1'b0; acc_len = 16'd0;
    send(32'hFFFFFFF9);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hFFFFFFF9) begin fails++; $display("FAIL len0: got v=%b d=%h want v=1 d=fffffff9", out_valid, out_data); end
    handshake();
    acc_len = 16'd2;
    send(32'h0000FFFF);
    choose_8bit = 1'b1;
    send(32'h0000FFFF);
    checks++; if (out_data !== 32'h0001FFFE) begin fails++; $display("FAIL mode_latch: got %h want 0001fffe", out_data); end
    handshake();
    choose_8bit = 1'b0;
  endtask

  task automatic test_mid_reset();
    acc_len = 16'd4;
    send(32'd1); send(32'd1);
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
    step();
    reset = 1'b0;
    step();
    acc_len = 16'd2;
    send(32'd1); send(32'd2);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd3) begin fails++; $display("FAIL midrst_after: got v=%b d=%h want v=1 d=3", out_valid, out_data); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_full_sum();
    test_packed_sum();
    test_saturation();
    test_backpressure();
    test_len_zero_and_mode_latch();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
